// File: rtl/wb_scoreboard_if.sv
// wb_scoreboard_if: issue, writeback and RegFile signals shared by the scoreboard and its neighbours.
interface wb_scoreboard_if;
   logic        issue_valid, issue_use_rs1, issue_use_rs2, issue_long;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        alu_wb_valid, long_wb_valid, long_wb_ready;
   logic [4:0]  alu_wb_rd, long_wb_rd;
   logic [31:0] alu_wb_res, long_wb_res;
   logic        rf_we, stall;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata, busy_o;
   modport master (
      output issue_valid, issue_use_rs1, issue_use_rs2, issue_long, issue_rs1, issue_rs2, issue_rd,
      output alu_wb_valid, alu_wb_rd, alu_wb_res, long_wb_valid, long_wb_rd, long_wb_res,
      input  long_wb_ready, rf_we, rf_rd, rf_wdata, stall, busy_o
   );
   modport slave (
      input  issue_valid, issue_use_rs1, issue_use_rs2, issue_long, issue_rs1, issue_rs2, issue_rd,
      input  alu_wb_valid, alu_wb_rd, alu_wb_res, long_wb_valid, long_wb_rd, long_wb_res,
      output long_wb_ready, rf_we, rf_rd, rf_wdata, stall, busy_o
   );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: RegFile writeback arbiter (ALU over long unit) plus long-latency register scoreboard and decode stall.
module wb_scoreboard #(
   parameter int MAX_LONG = 4,
   parameter int STARVE_LIMIT = 3
) (
   input logic clk,
   input logic rst,
   wb_scoreboard_if.slave bus
);
   localparam int OW = $clog2(MAX_LONG + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [OW-1:0] OUT_MAX = OW'(MAX_LONG);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   logic [31:0] busy_q, busy_d;
   logic [OW-1:0] outstanding_q, outstanding_d;
   logic [SW-1:0] starve_q, starve_d;
   logic long_xfer, set_en, clr_en, hazard;
   always_comb begin
      bus.long_wb_ready = !rst && !bus.alu_wb_valid;
      long_xfer = bus.long_wb_valid && bus.long_wb_ready;
      bus.rf_we = !rst && (bus.alu_wb_valid ? bus.alu_wb_rd != '0 : long_xfer && bus.long_wb_rd != '0);
      bus.rf_rd = bus.alu_wb_valid ? bus.alu_wb_rd : bus.long_wb_rd;
      bus.rf_wdata = bus.alu_wb_valid ? bus.alu_wb_res : bus.long_wb_res;
      hazard = bus.issue_valid && ((bus.issue_use_rs1 && busy_q[bus.issue_rs1]) ||
                                   (bus.issue_use_rs2 && busy_q[bus.issue_rs2]) ||
                                   (bus.issue_rd != '0 && busy_q[bus.issue_rd]) ||
                                   (bus.issue_long && bus.issue_rd != '0 && outstanding_q == OUT_MAX));
      bus.stall = rst || hazard || starve_q == STARVE_MAX;
      set_en = bus.issue_valid && !bus.stall && bus.issue_long && bus.issue_rd != '0;
      // Results landing after a reset find their bit already clear, so they never decrement.
      clr_en = long_xfer && busy_q[bus.long_wb_rd];
      busy_d = busy_q;
      if (clr_en) busy_d[bus.long_wb_rd] = 1'b0;
      if (set_en) busy_d[bus.issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
      outstanding_d = outstanding_q + OW'(set_en) - OW'(clr_en);
      starve_d = (bus.long_wb_valid && !bus.long_wb_ready) ? starve_q + SW'(starve_q != STARVE_MAX) : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         outstanding_q <= '0;
         starve_q <= '0;
      end else begin
         busy_q <= busy_d;
         outstanding_q <= outstanding_d;
         starve_q <= starve_d;
      end
   end
   assign bus.busy_o = busy_q;
   a_alu_busy: assert property (@(posedge clk) disable iff (rst) bus.alu_wb_valid |-> !busy_q[bus.alu_wb_rd]);
   a_long_idle: assert property (@(posedge clk) disable iff (rst) long_xfer && bus.long_wb_rd != '0 |-> busy_q[bus.long_wb_rd]);
   a_over: assert property (@(posedge clk) disable iff (rst) set_en && !clr_en |-> outstanding_q != OUT_MAX);
   a_under: assert property (@(posedge clk) disable iff (rst) clr_en && !set_en |-> outstanding_q != '0);
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: table vectors, hand sequences and randomized traffic checked against an in-flight-list model.
module tb_wb_scoreboard;
   localparam int MAX_LONG = 4;
   localparam int STARVE_LIMIT = 3;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   wb_scoreboard_if bus ();
   wb_scoreboard #(.MAX_LONG(MAX_LONG), .STARVE_LIMIT(STARVE_LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      bit rst, iv, u1, u2, lng, av, lv;
      logic [4:0] rs1, rs2, rd, ard, lrd;
      bit e_stall, e_ready, e_we;
      logic [31:0] e_busy;
   } vec_t;
   vec_t tbl [13];
   int n_cmp = 0;
   int n_bad = 0;
   int inflight[$];
   int starve_m = 0;
   bit hold = 0;
   bit e_ready, e_stall, e_we;
   function automatic bit inf(int r);
      foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
      return 1'b0;
   endfunction
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask
   task automatic clr_in();
      {bus.issue_valid, bus.issue_use_rs1, bus.issue_use_rs2, bus.issue_long} = '0;
      {bus.issue_rs1, bus.issue_rs2, bus.issue_rd} = '0;
      {bus.alu_wb_valid, bus.alu_wb_rd, bus.alu_wb_res} = '0;
      {bus.long_wb_valid, bus.long_wb_rd, bus.long_wb_res} = '0;
   endtask
   task automatic settle_check();
      logic [31:0] eb;
      bit xfer, haz;
      #1;
      e_ready = !rst && !bus.alu_wb_valid;
      xfer = bus.long_wb_valid && e_ready;
      e_we = !rst && (bus.alu_wb_valid ? bus.alu_wb_rd != 0 : xfer && bus.long_wb_rd != 0);
      haz = bus.issue_valid && ((bus.issue_use_rs1 && inf(bus.issue_rs1)) || (bus.issue_use_rs2 && inf(bus.issue_rs2)) ||
            (bus.issue_rd != 0 && inf(bus.issue_rd)) || (bus.issue_long && bus.issue_rd != 0 && inflight.size() == MAX_LONG));
      e_stall = rst || haz || starve_m >= STARVE_LIMIT;
      eb = '0;
      foreach (inflight[i]) eb[inflight[i]] = 1'b1;
      chk("stall", 32'(bus.stall), 32'(e_stall));
      chk("long_wb_ready", 32'(bus.long_wb_ready), 32'(e_ready));
      chk("rf_we", 32'(bus.rf_we), 32'(e_we));
      chk("busy_o", bus.busy_o, eb);
      if (e_we) begin
         chk("rf_rd", 32'(bus.rf_rd), 32'(bus.alu_wb_valid ? bus.alu_wb_rd : bus.long_wb_rd));
         chk("rf_wdata", bus.rf_wdata, bus.alu_wb_valid ? bus.alu_wb_res : bus.long_wb_res);
      end
   endtask
   task automatic tick();
      bit r, lv, iv, lng;
      int lrd, rd;
      r = rst; lv = bus.long_wb_valid; lrd = bus.long_wb_rd;
      iv = bus.issue_valid; lng = bus.issue_long; rd = bus.issue_rd;
      @(posedge clk);
      if (r) begin
         inflight.delete();
         starve_m = 0;
         hold = 0;
      end else begin
         if (lv && e_ready && lrd != 0)
            for (int i = 0; i < inflight.size(); i++)
               if (inflight[i] == lrd) begin
                  inflight.delete(i);
                  break;
               end
         if (iv && !e_stall && lng && rd != 0) inflight.push_back(rd);
         starve_m = (lv && !e_ready) ? ((starve_m + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve_m + 1) : 0;
         hold = lv && !e_ready;
      end
      @(negedge clk);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      clr_in();
      settle_check();
      tick();
      rst = 1'b0;
   endtask
   initial begin
      clr_in();
      //          rst iv u1 u2 lg av lv rs1 rs2 rd ard lrd  st rdy we busy
      tbl = '{'{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0},
              '{0, 1, 0, 0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 1, 0, 32'h0},
              '{0, 1, 1, 1, 0, 0, 0, 5, 1, 6, 0, 0, 1, 1, 0, 32'h20},
              '{0, 1, 1, 1, 0, 1, 0, 5, 1, 6, 7, 0, 1, 0, 1, 32'h20},
              '{0, 1, 1, 1, 0, 0, 1, 5, 1, 6, 0, 5, 1, 1, 1, 32'h20},
              '{0, 1, 1, 1, 0, 0, 0, 5, 1, 6, 0, 0, 0, 1, 0, 32'h0},
              '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0},
              '{0, 1, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 32'h0},
              '{0, 1, 0, 0, 1, 0, 1, 0, 0, 9, 0, 3, 0, 1, 1, 32'h8},
              '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h200},
              '{0, 1, 0, 0, 1, 0, 0, 0, 0, 12, 0, 0, 0, 1, 0, 32'h200},
              '{1, 1, 0, 0, 1, 0, 0, 0, 0, 13, 0, 0, 1, 0, 0, 32'h1200},
              '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0}};
      @(negedge clk);
      for (int i = 0; i < 13; i++) begin
         rst = tbl[i].rst;
         bus.issue_valid = tbl[i].iv; bus.issue_use_rs1 = tbl[i].u1; bus.issue_use_rs2 = tbl[i].u2;
         bus.issue_long = tbl[i].lng; bus.issue_rs1 = tbl[i].rs1; bus.issue_rs2 = tbl[i].rs2; bus.issue_rd = tbl[i].rd;
         bus.alu_wb_valid = tbl[i].av; bus.alu_wb_rd = tbl[i].ard; bus.alu_wb_res = 32'hA000_0000 | 32'(tbl[i].ard);
         bus.long_wb_valid = tbl[i].lv; bus.long_wb_rd = tbl[i].lrd; bus.long_wb_res = 32'hB000_0000 | 32'(tbl[i].lrd);
         settle_check();
         chk($sformatf("vec%0d stall", i), 32'(bus.stall), 32'(tbl[i].e_stall));
         chk($sformatf("vec%0d ready", i), 32'(bus.long_wb_ready), 32'(tbl[i].e_ready));
         chk($sformatf("vec%0d rf_we", i), 32'(bus.rf_we), 32'(tbl[i].e_we));
         chk($sformatf("vec%0d busy", i), bus.busy_o, tbl[i].e_busy);
         tick();
      end
      // outstanding limit: x1..x4 in flight, fifth long op waits for a commit
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         clr_in();
         bus.issue_valid = 1; bus.issue_long = 1; bus.issue_rd = 5'(i);
         settle_check();
         chk("limit fill stall", 32'(bus.stall), 0);
         tick();
      end
      bus.issue_rd = 7;
      for (int i = 0; i < 2; i++) begin
         settle_check();
         chk("limit full stall", 32'(bus.stall), 1);
         chk("limit outstanding 4", 32'($countones(bus.busy_o)), 4);
         tick();
      end
      bus.long_wb_valid = 1; bus.long_wb_rd = 2; bus.long_wb_res = 32'h1234_5678;
      settle_check();
      chk("limit commit stall", 32'(bus.stall), 1);
      chk("limit commit data", bus.rf_wdata, 32'h1234_5678);
      tick();
      bus.long_wb_valid = 0;
      settle_check();
      chk("limit release stall", 32'(bus.stall), 0);
      chk("limit outstanding 3", 32'($countones(bus.busy_o)), 3);
      tick();
      clr_in();
      settle_check();
      chk("limit outstanding 4 again", 32'($countones(bus.busy_o)), 4);
      chk("limit busy set", bus.busy_o, 32'h9A);
      tick();
      // starvation: ALU keeps winning, decode stalls on the fourth refused cycle
      do_reset();
      bus.issue_valid = 1; bus.issue_long = 1; bus.issue_rd = 5;
      settle_check();
      tick();
      clr_in();
      bus.alu_wb_valid = 1; bus.alu_wb_rd = 8; bus.alu_wb_res = 32'h0000_0808;
      bus.long_wb_valid = 1; bus.long_wb_rd = 5; bus.long_wb_res = 32'hCAFE_0005;
      for (int c = 1; c <= 4; c++) begin
         settle_check();
         chk($sformatf("starve c%0d ready", c), 32'(bus.long_wb_ready), 0);
         chk($sformatf("starve c%0d stall", c), 32'(bus.stall), 32'(c == 4));
         tick();
      end
      bus.alu_wb_valid = 0;
      settle_check();
      chk("starve bubble ready", 32'(bus.long_wb_ready), 1);
      chk("starve bubble rf_we", 32'(bus.rf_we), 1);
      chk("starve bubble rf_rd", 32'(bus.rf_rd), 5);
      chk("starve bubble wdata", bus.rf_wdata, 32'hCAFE_0005);
      tick();
      bus.long_wb_valid = 0;
      settle_check();
      chk("starve cleared stall", 32'(bus.stall), 0);
      chk("starve cleared busy", bus.busy_o, 0);
      tick();
      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 800; k++) begin
         rst = ($urandom_range(0, 60) == 0);
         bus.issue_valid = ($urandom_range(0, 3) != 0);
         bus.issue_use_rs1 = 1'($urandom_range(0, 1));
         bus.issue_use_rs2 = 1'($urandom_range(0, 1));
         bus.issue_long = 1'($urandom_range(0, 1));
         bus.issue_rs1 = 5'($urandom_range(0, 7));
         bus.issue_rs2 = 5'($urandom_range(0, 7));
         bus.issue_rd = 5'($urandom_range(0, 7));
         bus.alu_wb_rd = 5'($urandom_range(0, 7));
         bus.alu_wb_res = $urandom;
         bus.alu_wb_valid = $urandom_range(0, 1) == 1 && !inf(bus.alu_wb_rd);
         if (!hold) begin
            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
               bus.long_wb_valid = 1;
               bus.long_wb_rd = 5'(inflight[$urandom_range(0, inflight.size() - 1)]);
               bus.long_wb_res = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
               bus.long_wb_valid = 1;
               bus.long_wb_rd = 0;
               bus.long_wb_res = $urandom;
            end else bus.long_wb_valid = 0;
         end
         settle_check();
         tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
